// File: rtl/button_conditioner.sv
// button_conditioner: turns a raw, bouncing push-button level into a
// single-cycle count-enable pulse `w`. The path is a two-flop
// synchroniser, then a counting debouncer, then a press/auto-repeat FSM.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pressed,
  output logic w,
  output logic repeating
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, HELD_DELAY, HELD_REPEAT} state_e;

  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed_q, pressed_d;
  logic          press_evt, rel_evt;
  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          w_q, w_d;

  // Two-flop synchroniser for the asynchronous button level
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_in;
      s2_q <= s1_q;
    end
  end

  // Debouncer next state: count disagreeing samples and flip the level on the Nth one
  always_comb begin
    cnt_d     = '0;
    pressed_d = pressed_q;
    if (s2_q != pressed_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) pressed_d = s2_q;
      else                                   cnt_d     = cnt_q + 1'b1;
    end
  end

  // Press/release events are taken from the debouncer's next state, so that
  // w and pressed rise on the same edge
  assign press_evt = pressed_d & ~pressed_q;
  assign rel_evt   = ~pressed_d & pressed_q;

  // FSM next state: press pulse, delayed first repeat, then periodic repeats.
  // A release beats a coincident repeat tick.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    w_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_evt) begin
          w_d     = 1'b1;
          tmr_d   = TW'(1);
          state_d = HELD_DELAY;
        end
      end
      HELD_DELAY: begin
        if (rel_evt) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if (tmr_q == TW'(REPEAT_DELAY)) begin
          // With repeat disabled the timer simply saturates here
          if (REPEAT_EN != 0) begin
            w_d     = 1'b1;
            tmr_d   = TW'(1);
            state_d = HELD_REPEAT;
          end
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      HELD_REPEAT: begin
        if (rel_evt) begin
          state_d = IDLE;
          tmr_d   = '0;
        end else if (tmr_q == TW'(REPEAT_PERIOD)) begin
          w_d   = 1'b1;
          tmr_d = TW'(1);
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Debouncer and FSM state registers; reset overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      state_q   <= IDLE;
      tmr_q     <= '0;
      w_q       <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      w_q       <= w_d;
    end
  end

  assign pressed   = pressed_q;
  assign w         = w_q;
  assign repeating = (state_q == HELD_REPEAT);

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: a per-edge vector table covering
// reset, a clean press and bounce rejection, followed by hand sequences for
// auto-repeat, a release that coincides with a repeat tick, and a reset mid-hold.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst, btn_in;
  logic pressed, w, repeating;
  logic pressed_nr, w_nr, rep_nr;

  always #5 clk = ~clk;

  button_conditioner dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .pressed(pressed), .w(w), .repeating(repeating)
  );

  button_conditioner #(.REPEAT_EN(0)) dut_nr (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .pressed(pressed_nr), .w(w_nr), .repeating(rep_nr)
  );

  typedef struct {
    logic rst;
    logic btn;
    logic exp_p;
    logic exp_w;
    logic exp_r;
  } vec_t;

  localparam int NV = 54;
  vec_t vecs[NV];

  int checks = 0;
  int errors = 0;
  int edge_n = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d got %0d want %0d", nm, edge_n, act, exp);
    end
  endtask

  // Apply inputs for one rising edge and settle just after it
  task automatic tick(input logic r, input logic b);
    @(negedge clk);
    rst    = r;
    btn_in = b;
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  int q[$];
  int e0, off, nr_cnt, nr_rep;
  int exp_long[7] = '{0, 8, 12, 16, 20, 24, 28};
  int exp_coin[2] = '{0, 8};
  int exp_rst[7]  = '{0, 8, 16, 24, 28, 32, 36};

  initial begin
    rst    = 1'b1;
    btn_in = 1'b0;

    // Vector i drives edge i; expected values are those seen just after edge i
    for (int i = 0; i < NV; i++) vecs[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[0].rst = 1'b1;
    vecs[1].rst = 1'b1;
    // clean press: btn 1 on edges 12..19, so pressed spans 17..24 and w is high at 17
    for (int i = 12; i <= 19; i++) vecs[i].btn = 1'b1;
    for (int i = 17; i <= 24; i++) vecs[i].exp_p = 1'b1;
    vecs[17].exp_w = 1'b1;
    // bounce 1,1,1,0,1,1,0,1,1,1,1 from edge 30, held through 43, pressed at 42..48
    for (int i = 30; i <= 43; i++) vecs[i].btn = 1'b1;
    vecs[33].btn = 1'b0;
    vecs[36].btn = 1'b0;
    for (int i = 42; i <= 48; i++) vecs[i].exp_p = 1'b1;
    vecs[42].exp_w = 1'b1;

    for (int i = 0; i < NV; i++) begin
      tick(vecs[i].rst, vecs[i].btn);
      chk("tbl_pressed", pressed, vecs[i].exp_p);
      chk("tbl_w", w, vecs[i].exp_w);
      chk("tbl_repeating", repeating, vecs[i].exp_r);
    end

    // Long hold: press pulse P = e0+5; btn released so pressed falls at P+30
    e0 = edge_n + 1;
    q.delete();
    nr_cnt = 0;
    nr_rep = 0;
    for (int j = 0; j < 46; j++) begin
      tick(1'b0, j < 30);
      off = edge_n - (e0 + 5);
      if (w) q.push_back(off);
      if (w_nr) nr_cnt++;
      if (rep_nr) nr_rep++;
      if (off == 7)  chk("long_rep_before", repeating, 1'b0);
      if (off == 8)  chk("long_rep_first", repeating, 1'b1);
      if (off == 29) chk("long_pressed_held", pressed, 1'b1);
      if (off == 30) begin
        chk("long_pressed_rel", pressed, 1'b0);
        chk("long_rep_rel", repeating, 1'b0);
      end
    end
    chk("long_pulse_count", q.size(), 7);
    for (int i = 0; i < 7; i++) chk("long_pulse_at", (i < q.size()) ? q[i] : -1, exp_long[i]);
    chk("norep_pulse_count", nr_cnt, 1);
    chk("norep_repeating", nr_rep, 0);

    // Release lands on the P+12 repeat tick: the release must win
    e0 = edge_n + 1;
    q.delete();
    for (int j = 0; j < 30; j++) begin
      tick(1'b0, j < 12);
      off = edge_n - (e0 + 5);
      if (w) q.push_back(off);
      if (off == 11) chk("coin_rep_before", repeating, 1'b1);
      if (off == 12) begin
        chk("coin_w", w, 1'b0);
        chk("coin_pressed", pressed, 1'b0);
        chk("coin_rep", repeating, 1'b0);
      end
    end
    chk("coin_pulse_count", q.size(), 2);
    for (int i = 0; i < 2; i++) chk("coin_pulse_at", (i < q.size()) ? q[i] : -1, exp_coin[i]);

    // Reset at P+10 with the button held; the fresh press is seen at P+16
    e0 = edge_n + 1;
    q.delete();
    for (int j = 0; j < 56; j++) begin
      tick(j == 15, j < 40);
      off = edge_n - (e0 + 5);
      if (w) q.push_back(off);
      if (off == 9) chk("rst_rep_before", repeating, 1'b1);
      if (off == 10) begin
        chk("rst_pressed", pressed, 1'b0);
        chk("rst_w", w, 1'b0);
        chk("rst_rep", repeating, 1'b0);
      end
      if (off == 15) chk("rst_pressed_pre", pressed, 1'b0);
      if (off == 16) chk("rst_pressed_new", pressed, 1'b1);
    end
    chk("rst_pulse_count", q.size(), 7);
    for (int i = 0; i < 7; i++) chk("rst_pulse_at", (i < q.size()) ? q[i] : -1, exp_rst[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
